// File: rtl/starfield_rx_pkg.sv
// Shared definitions for the starfield_rx VGA sink: lock FSM states,
// default raster timing and the CRC-16/CCITT constants and step function.
package starfield_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    localparam int DEF_H_DISPLAY    = 256;
    localparam int DEF_H_SYNC_START = 263;
    localparam int DEF_H_TOTAL      = 309;
    localparam int DEF_V_DISPLAY    = 240;
    localparam int DEF_V_SYNC_START = 245;
    localparam int DEF_V_TOTAL      = 262;
    localparam int DEF_LOCK_FRAMES  = 2;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Shift one 3-bit pixel into the CRC, rgb[2] first.
    function automatic logic [15:0] crc16_step3(input logic [15:0] crc_in,
                                                input logic [2:0]  sym);
        logic [15:0] c;
        c = crc_in;
        for (int i = 2; i >= 0; i--) begin
            if (c[15] ^ sym[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_frame_crc.sv
// Per-frame CRC-16 accumulator: one 3-bit symbol per enabled cycle.
// i_clear restarts from CRC_INIT; clear and enable together restart and
// absorb the current symbol. o_crc_next is the value after this cycle.
module vga_frame_crc
    import starfield_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [2:0]  i_data,
    output logic [15:0] o_crc_next
);

    logic [15:0] r_crc;
    logic [15:0] w_base;
    logic [15:0] w_crc_next;

    // Select the starting value and optionally absorb the symbol.
    always_comb begin
        w_base     = i_clear ? CRC_INIT : r_crc;
        w_crc_next = i_en ? crc16_step3(w_base, i_data) : w_base;
    end

    // Running CRC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= CRC_INIT;
        end else begin
            r_crc <= w_crc_next;
        end
    end

    assign o_crc_next = w_crc_next;

endmodule

// File: rtl/starfield_rx.sv
// starfield_rx: VGA sink that recovers hpos/vpos from hsync/vsync, checks
// the raster timing, locks after LOCK_FRAMES good frames and reports a
// lit-pixel count and CRC-16 for every fully locked visible frame.
// Optional build macro STARFIELD_RX_BORDER_CHECK_EN: non-zero rgb during
// blanking while locked is treated as a timing violation.
module starfield_rx
    import starfield_rx_pkg::*;
#(
    parameter int H_DISPLAY    = DEF_H_DISPLAY,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_DISPLAY    = DEF_V_DISPLAY,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int LOCK_FRAMES  = DEF_LOCK_FRAMES,
    parameter bit SYNC_ACTIVE  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic [15:0] hpos,
    output logic [15:0] vpos,
    output logic        locked,
    output logic        display_on,
    output logic        sync_error,
    output logic        frame_done,
    output logic [15:0] star_count,
    output logic [15:0] frame_crc
);

    localparam logic [15:0] HD_W     = 16'(H_DISPLAY);
    localparam logic [15:0] HSS_W    = 16'(H_SYNC_START);
    localparam logic [15:0] HSS_P1_W = 16'(H_SYNC_START + 1);
    localparam logic [15:0] HT_M1_W  = 16'(H_TOTAL - 1);
    localparam logic [15:0] VD_W     = 16'(V_DISPLAY);
    localparam logic [15:0] VSS_W    = 16'(V_SYNC_START);
    localparam logic [15:0] VT_M1_W  = 16'(V_TOTAL - 1);
    localparam logic [15:0] HD_M1_W  = 16'(H_DISPLAY - 1);
    localparam logic [15:0] VD_M1_W  = 16'(V_DISPLAY - 1);
    localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

    // Input stage and sync history
    logic        r_hsync, r_vsync, r_hsync_prev, r_vsync_prev;
    logic [2:0]  r_rgb;
    // Position of the previous sample; the current sample is predicted from it
    logic [15:0] r_hcnt, r_vcnt;
    logic        r_hs_edge_prev;
    logic        r_vs_seen;
    rx_state_t   r_state;
    logic [7:0]  r_good_cnt;
    logic [15:0] r_count;
    logic        r_frame_ok;
    logic        r_frame_done;
    logic [15:0] r_star_count, r_frame_crc;

    logic        w_hs_edge, w_vs_edge, w_hwrap;
    logic [15:0] w_pred_h, w_pred_v, w_hpos, w_vpos;
    logic        w_hs_err, w_vs_err, w_border_err, w_err, w_vs_good;
    logic        w_area, w_locked, w_display_on, w_first, w_last;
    logic [15:0] w_count_next, w_crc_next;
    rx_state_t   w_state_next;
    logic [7:0]  w_good_next;

    // Register the raw inputs and keep one older sync sample for edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync      <= ~SYNC_ACTIVE;
            r_vsync      <= ~SYNC_ACTIVE;
            r_hsync_prev <= ~SYNC_ACTIVE;
            r_vsync_prev <= ~SYNC_ACTIVE;
            r_rgb        <= 3'd0;
        end else begin
            r_hsync      <= hsync;
            r_vsync      <= vsync;
            r_hsync_prev <= r_hsync;
            r_vsync_prev <= r_vsync;
            r_rgb        <= rgb;
        end
    end

    // Predict the current sample's position, then apply sync-edge forcing
    // and evaluate every timing violation for this sample.
    always_comb begin
        w_hs_edge = (r_hsync == SYNC_ACTIVE) && (r_hsync_prev != SYNC_ACTIVE);
        w_vs_edge = (r_vsync == SYNC_ACTIVE) && (r_vsync_prev != SYNC_ACTIVE);
        w_hwrap   = (r_hcnt == HT_M1_W);
        w_pred_h  = w_hwrap ? 16'd0 : r_hcnt + 16'd1;
        if (w_hwrap) begin
            w_pred_v = (r_vcnt == VT_M1_W) ? 16'd0 : r_vcnt + 16'd1;
        end else begin
            w_pred_v = r_vcnt;
        end
        w_hpos = w_hs_edge ? HSS_W : w_pred_h;
        w_vpos = w_vs_edge ? VSS_W : w_pred_v;

        w_vs_good = w_vs_edge && (w_pred_v == VSS_W) && (w_pred_h == HSS_W);
        // A missing hsync shows up one pixel after its slot with no edge
        // on the previous sample.
        w_hs_err = w_hs_edge ? (w_pred_h != HSS_W)
                             : ((w_pred_h == HSS_P1_W) && !r_hs_edge_prev);
        // A missing vsync shows up when the sync line ends without an edge.
        w_vs_err = w_vs_edge ? !w_vs_good
                             : (w_hwrap && (r_vcnt == VSS_W) && !r_vs_seen);
        w_area = (w_hpos < HD_W) && (w_vpos < VD_W);
`ifdef STARFIELD_RX_BORDER_CHECK_EN
        w_border_err = (r_state == LOCKED) && !w_area && (r_rgb != 3'd0);
`else
        w_border_err = 1'b0;
`endif
        w_err = (r_state != SEARCH) && (w_hs_err || w_vs_err || w_border_err);

        w_locked     = (r_state == LOCKED) && !w_err;
        w_display_on = w_locked && w_area;
        w_first      = (w_hpos == 16'd0) && (w_vpos == 16'd0);
        w_last       = (w_hpos == HD_M1_W) && (w_vpos == VD_M1_W);
    end

    // Position counters and per-line/frame sync bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Chosen so the first sample after reset predicts (0,0).
            r_hcnt         <= HT_M1_W;
            r_vcnt         <= VT_M1_W;
            r_hs_edge_prev <= 1'b0;
            r_vs_seen      <= 1'b0;
        end else begin
            r_hcnt         <= w_hpos;
            r_vcnt         <= w_vpos;
            r_hs_edge_prev <= w_hs_edge;
            if (w_vs_edge) begin
                r_vs_seen <= 1'b1;
            end else if (w_hwrap && (r_vcnt == VSS_W)) begin
                r_vs_seen <= 1'b0;
            end
        end
    end

    // Lock FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_good_next  = r_good_cnt;
        case (r_state)
            SEARCH: begin
                if (w_vs_edge) begin
                    w_state_next = ACQUIRE;
                    w_good_next  = 8'd0;
                end
            end
            ACQUIRE: begin
                if (w_err) begin
                    w_state_next = SEARCH;
                end else if (w_vs_good) begin
                    w_good_next = r_good_cnt + 8'd1;
                    if (w_good_next == LOCK_N) begin
                        w_state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_err) begin
                    w_state_next = SEARCH;
                end
            end
            default: w_state_next = SEARCH;
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SEARCH;
            r_good_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_next;
        end
    end

    // Saturating lit-pixel count, restarted at the first pixel of a frame.
    always_comb begin
        w_count_next = r_count;
        if (w_first) begin
            w_count_next = 16'd0;
        end
        if (w_display_on && (r_rgb != 3'd0) && (w_count_next != 16'hFFFF)) begin
            w_count_next = w_count_next + 16'd1;
        end
    end

    vga_frame_crc u_crc (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_first),
        .i_en       (w_display_on),
        .i_data     (r_rgb),
        .o_crc_next (w_crc_next)
    );

    // Accumulate statistics and publish them after a fully locked frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= 16'd0;
            r_frame_ok   <= 1'b0;
            r_frame_done <= 1'b0;
            r_star_count <= 16'd0;
            r_frame_crc  <= 16'd0;
        end else begin
            r_count <= w_count_next;
            if (w_first) begin
                r_frame_ok <= w_locked;
            end else if (!w_locked) begin
                r_frame_ok <= 1'b0;
            end
            r_frame_done <= w_display_on && w_last && r_frame_ok;
            if (w_display_on && w_last && r_frame_ok) begin
                r_star_count <= w_count_next;
                r_frame_crc  <= w_crc_next;
            end
        end
    end

    assign hpos       = w_hpos;
    assign vpos       = w_vpos;
    assign locked     = w_locked;
    assign display_on = w_display_on;
    assign sync_error = w_err;
    assign frame_done = r_frame_done;
    assign star_count = r_star_count;
    assign frame_crc  = r_frame_crc;

endmodule

// File: tb/tb_starfield_rx.sv
// Directed bench for starfield_rx on a reduced raster (32x24 visible,
// 40x30 total) so many frames fit in a short run. A bench-side raster
// generator drives hsync/vsync/rgb; expected values are hand-derived or
// come from a small reference CRC model.
module tb_starfield_rx;

    localparam int HD  = 32;
    localparam int HSS = 35;
    localparam int HT  = 40;
    localparam int VD  = 24;
    localparam int VSS = 26;
    localparam int VT  = 30;
`ifdef STARFIELD_RX_BORDER_CHECK_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync, vsync;
    logic [2:0]  rgb;
    logic [15:0] hpos, vpos, star_count, frame_crc;
    logic        locked, display_on, sync_error, frame_done;

    always #5 clk = ~clk;

    starfield_rx #(
        .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_TOTAL(VT),
        .LOCK_FRAMES(2), .SYNC_ACTIVE(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .hpos(hpos), .vpos(vpos), .locked(locked), .display_on(display_on),
        .sync_error(sync_error), .frame_done(frame_done),
        .star_count(star_count), .frame_crc(frame_crc)
    );

    int n_pass = 0, n_fail = 0, n_total = 0;
    int gf = 0, gv = 0, gh = 0;     // pixel being driven
    int sf = -1, sv = -1, sh = -1;  // pixel the DUT is currently showing
    int mode = 0;
    int err_cnt = 0, done_cnt = 0;

    function automatic logic [2:0] pix_at(input int m, input int h, input int v);
        if (m == 1) return 3'b111;
        if (m == 2 && h == 10 && v == 20) return 3'b101;
        return 3'b000;
    endfunction

    function automatic logic [31:0] model_crc(input int m);
        logic [15:0] c;
        logic [2:0]  p;
        c = 16'hFFFF;
        for (int v = 0; v < VD; v++) begin
            for (int h = 0; h < HD; h++) begin
                p = pix_at(m, h, v);
                for (int b = 2; b >= 0; b--) begin
                    if (c[15] ^ p[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
                    else              c = {c[14:0], 1'b0};
                end
            end
        end
        return {16'd0, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        int hs_lo;
        hs_lo = (gf == 6 && gv == 5) ? HSS + 1 : HSS;   // one late hsync edge
        hsync = (gh >= hs_lo) && (gh <= HSS + 3);
        vsync = (gv == VSS && gh >= HSS) || (gv == VSS + 1) || (gv == VSS + 2 && gh < HSS);
        if (gh < HD && gv < VD)                    rgb = pix_at(mode, gh, gv);
        else if (gf == 14 && gv == 3 && gh == 37)  rgb = 3'b001;
        else                                       rgb = 3'b000;
    endtask

    task automatic step();
        @(posedge clk); #1;
        sf = gf; sv = gv; sh = gh;
        if (sync_error) err_cnt++;
        if (frame_done) done_cnt++;
        gh++;
        if (gh == HT) begin
            gh = 0; gv++;
            if (gv == VT) begin gv = 0; gf++; end
        end
        drive();
    endtask

    task automatic run_to(input int f, input int v, input int h);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(sf == f && sv == v && sh == h) && n < 20000);
        chk("reach_target", {31'd0, (sf == f && sv == v && sh == h)}, 32'd1);
    endtask

    task automatic chk_reset_values(input string pfx);
        chk({pfx, "_hpos"}, hpos, 0);
        chk({pfx, "_vpos"}, vpos, 0);
        chk({pfx, "_locked"}, locked, 0);
        chk({pfx, "_display_on"}, display_on, 0);
        chk({pfx, "_sync_error"}, sync_error, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_star_count"}, star_count, 0);
        chk({pfx, "_frame_crc"}, frame_crc, 0);
    endtask

    task automatic chk_frame(input string pfx, input int cnt, input int m);
        chk({pfx, "_done"}, frame_done, 1);
        chk({pfx, "_count"}, star_count, cnt);
        chk({pfx, "_crc"}, frame_crc, model_crc(m));
        $display("frame %0d: done=%0b count=%0d crc=%04h", sf, frame_done, star_count, frame_crc);
    endtask

    initial begin
        reset = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("init");
        $display("reset: hpos=%0d vpos=%0d locked=%0b", hpos, vpos, locked);
        reset = 1'b0;

        // Lock: third vsync edge (frame 2) sets LOCKED, visible next cycle
        run_to(2, VSS, HSS);
        chk("lock_pre", locked, 0);
        step();
        chk("lock_post", locked, 1);
        $display("lock at frame %0d line %0d px %0d: locked=%0b", sf, sv, sh, locked);

        // All-zero frame
        run_to(3, VD - 1, HD);
        chk_frame("zero", 0, 0);

        // All lit frame
        mode = 1;
        run_to(4, VD - 1, HD);
        chk_frame("full", VD * HD, 1);

        // Single pixel frame plus position recovery checks
        mode = 2;
        run_to(5, 20, 10);
        chk("pos_h", hpos, 10);
        chk("pos_v", vpos, 20);
        chk("pos_disp", display_on, 1);
        run_to(5, 20, HSS);
        chk("blank_disp", display_on, 0);
        chk("blank_h", hpos, HSS);
        run_to(5, VD - 1, HD);
        chk_frame("single", 1, 2);

        // Late hsync edge on frame 6 line 5
        run_to(6, 5, HSS);
        chk("late_pre_err", sync_error, 0);
        chk("late_pre_lock", locked, 1);
        err_cnt = 0;
        done_cnt = 0;
        step();
        chk("late_err", sync_error, 1);
        chk("late_lock", locked, 0);
        $display("late hsync: sync_error=%0b locked=%0b", sync_error, locked);
        run_to(8, VSS, HSS);
        chk("relock_pre", locked, 0);
        chk("relock_no_done", done_cnt, 0);
        step();
        chk("relock_post", locked, 1);
        run_to(9, VD - 1, HD);
        chk_frame("relock", 1, 2);
        chk("late_err_count", err_cnt, 1);

        // One-cycle reset in the middle of frame 10
        run_to(10, 10, 5);
        reset = 1'b1;
        step();
        chk_reset_values("midrst");
        $display("mid-frame reset: locked=%0b star_count=%0d", locked, star_count);
        reset = 1'b0;
        done_cnt = 0;
        run_to(12, VSS, HSS);
        chk("rst_relock_pre", locked, 0);
        chk("rst_no_done", done_cnt, 0);
        step();
        chk("rst_relock_post", locked, 1);
        run_to(13, VD - 1, HD);
        chk_frame("after_rst", 1, 2);

        // Non-zero rgb in horizontal blanking on frame 14
        run_to(14, 3, 36);
        chk("border_pre_lock", locked, 1);
        chk("border_pre_err", sync_error, 0);
        step();
        chk("border_err", sync_error, BORDER);
        chk("border_lock", locked, !BORDER);
        $display("border pixel: sync_error=%0b locked=%0b", sync_error, locked);
        done_cnt = 0;
        run_to(14, VD - 1, HD + 1);
        chk("border_done", done_cnt, BORDER ? 0 : 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
